// File: rtl/tft_spi_tx.sv
// Byte-wide SPI (mode 0) transmitter for the TFT panel.
// Holds CS low for a short window after each byte so streamed bytes share one burst.
module tft_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       dc_in,
    input  logic       transmit,
    output logic       busy,
    output logic       tft_sclk,
    output logic       tft_mosi,
    output logic       tft_cs,
    output logic       tft_dc
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] div_cnt, div_cnt_n;
    logic [7:0] idle_cnt, idle_cnt_n;
    logic       busy_n, sclk_n, mosi_n, cs_n, dc_n;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            idle_cnt <= '0;
            busy     <= 1'b0;
            tft_sclk <= 1'b0;
            tft_mosi <= 1'b0;
            tft_cs   <= 1'b1;
            tft_dc   <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            div_cnt  <= div_cnt_n;
            idle_cnt <= idle_cnt_n;
            busy     <= busy_n;
            tft_sclk <= sclk_n;
            tft_mosi <= mosi_n;
            tft_cs   <= cs_n;
            tft_dc   <= dc_n;
        end
    end

    // busy is only low in IDLE/GAP, so an accept in GAP wins over the CS timeout
    assign accept = transmit && !busy && (state == IDLE || state == GAP);

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        div_cnt_n  = div_cnt;
        idle_cnt_n = idle_cnt;
        busy_n     = busy;
        sclk_n     = tft_sclk;
        mosi_n     = tft_mosi;
        cs_n       = tft_cs;
        dc_n       = tft_dc;

        if (accept) begin
            shreg_n   = data;
            dc_n      = dc_in;
            mosi_n    = data[7];
            cs_n      = 1'b0;
            busy_n    = 1'b1;
            bit_cnt_n = 3'd7;
            div_cnt_n = '0;
            state_n   = SHIFT;
        end else begin
            unique case (state)
                IDLE: begin
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt_n = '0;
                        sclk_n    = ~tft_sclk;
                        if (tft_sclk) begin
                            if (bit_cnt != 3'd0) begin
                                shreg_n   = {shreg[6:0], 1'b0};
                                mosi_n    = shreg[6];
                                bit_cnt_n = bit_cnt - 3'd1;
                            end else begin
                                busy_n     = 1'b0;
                                sclk_n     = 1'b0;
                                idle_cnt_n = '0;
                                state_n    = GAP;
                            end
                        end
                    end else begin
                        div_cnt_n = div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    idle_cnt_n = idle_cnt + 8'd1;
                    if (idle_cnt == HOLD_LAST) begin
                        cs_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Randomized bench for tft_spi_tx: two instances (CLK_DIV=2/CS_HOLD=4 and
// CLK_DIV=1/CS_HOLD=2) checked against a byte-level timing model.
module tb_tft_spi_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       dc_in = 1'b0;
    logic       transmit = 1'b0;
    logic       sel = 1'b0;

    logic busy0, sclk0, mosi0, cs0, dc0;
    logic busy1, sclk1, mosi1, cs1, dc1;
    logic busy_m, sclk_m, mosi_m, cs_m, dc_m;

    int checks = 0;
    int errors = 0;

    int   rises = 0;
    int   cs_rises = 0;
    logic sclk_q = 1'b0;
    logic cs_q = 1'b1;
    logic bits[$];

    tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) u_dut0 (
        .clk(clk), .rst(rst), .data(data), .dc_in(dc_in),
        .transmit(transmit), .busy(busy0), .tft_sclk(sclk0),
        .tft_mosi(mosi0), .tft_cs(cs0), .tft_dc(dc0)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(2)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .dc_in(dc_in),
        .transmit(transmit), .busy(busy1), .tft_sclk(sclk1),
        .tft_mosi(mosi1), .tft_cs(cs1), .tft_dc(dc1)
    );

    assign busy_m = sel ? busy1 : busy0;
    assign sclk_m = sel ? sclk1 : sclk0;
    assign mosi_m = sel ? mosi1 : mosi0;
    assign cs_m   = sel ? cs1   : cs0;
    assign dc_m   = sel ? dc1   : dc0;

    always #5 clk = ~clk;

    // Panel-side view: what the panel latches on each SCLK rise.
    always @(negedge clk) begin
        if (sclk_m && !sclk_q) begin
            rises++;
            bits.push_back(mosi_m);
        end
        if (cs_m && !cs_q) cs_rises++;
        sclk_q = sclk_m;
        cs_q   = cs_m;
    end

    function automatic int cd();
        return sel ? 1 : 2;
    endfunction

    function automatic int ch();
        return sel ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte: accept, busy window, 8 panel samples MSB first.
    task automatic send(input logic [7:0] d, input logic dcv, input int coll);
        int         n;
        int         r0;
        logic [7:0] got;
        bits.delete();
        r0       = rises;
        data     = d;
        dc_in    = dcv;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        data     = 8'($urandom);
        dc_in    = 1'($urandom);
        check("busy_on", busy_m, 1);
        check("cs_low", cs_m, 0);
        check("dc", dc_m, dcv);
        check("mosi_msb", mosi_m, d[7]);
        n = 0;
        while (busy_m && n < 16 * cd() + 8) begin
            if (n == coll) begin
                data     = 8'h00;
                transmit = 1'b1;
            end
            tick();
            transmit = 1'b0;
            n++;
        end
        check("byte_time", n, 16 * cd());
        check("sclk_end", sclk_m, 0);
        check("cs_hold", cs_m, 0);
        check("rises", rises - r0, 8);
        got = '0;
        foreach (bits[i]) got = {got[6:0], bits[i]};
        check("bits", got, d);
    endtask

    // Idle gap after a byte, then the next byte; CS must release exactly at CS_HOLD.
    task automatic burst(input int g, input logic [7:0] d, input logic dcv,
                         input int coll);
        int c0;
        c0 = cs_rises;
        for (int i = 1; i <= g; i++) begin
            tick();
            check("cs_gap", cs_m, (i >= ch()) ? 1 : 0);
        end
        send(d, dcv, coll);
        check("cs_release", cs_rises - c0, (g >= ch()) ? 1 : 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy_m, 0);
        check({tag, "_cs"}, cs_m, 1);
        check({tag, "_sclk"}, sclk_m, 0);
        check({tag, "_dc"}, dc_m, 1);
        check({tag, "_mosi"}, mosi_m, 0);
    endtask

    initial begin
        int n;
        int r0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        rst = 1'b0;
        repeat (4) begin
            tick();
            check_idle("post_rst");
        end

        send(8'hA5, 1'b1, -1);
        burst(6, 8'h2C, 1'b0, -1);
        burst(0, 8'hFF, 1'b1, -1);
        burst(6, 8'h5A, 1'b1, -1);
        burst(0, 8'h81, 1'b1, 13);
        burst(3, 8'h96, 1'b0, -1);
        repeat (25) begin
            burst(int'($urandom_range(0, ch() + 3)), 8'($urandom), 1'($urandom),
                  ($urandom % 3 == 0) ? int'($urandom_range(1, 16 * cd() - 2)) : -1);
        end
        repeat (6) tick();

        r0       = rises;
        data     = 8'hC3;
        dc_in    = 1'b0;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        n = 0;
        while (rises - r0 < 3 && n < 100) begin
            tick();
            n++;
        end
        check("rst_wait", (n < 100) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_rst");

        sel = 1'b1;
        tick();
        send(8'h3C, 1'b0, -1);
        repeat (15) begin
            burst(int'($urandom_range(0, ch() + 3)), 8'($urandom), 1'($urandom),
                  ($urandom % 3 == 0) ? int'($urandom_range(1, 16 * cd() - 2)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
